// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU with registered zero flag
// Optional multiplier enabled by defining ALU_MUL_EN.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  input  logic             wzero,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_LUI   = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_PASSB = 4'b1101;

  logic [SHW-1:0]   shamt;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] mul_res;
  logic             zero_q;
  logic             zero_d;

  // Shifts use only the low SHW bits of a; upper bits are ignored.
  assign shamt       = a[SHW-1:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

`ifdef ALU_MUL_EN
  assign mul_res = a * b;
`else
  assign mul_res = '0;
`endif

  always_comb begin
    result = '0;
    unique case (aluc)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOR:   result = ~(a | b);
      OP_SLT:   result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU:  result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SLL:   result = b << shamt;
      OP_SRL:   result = b >> shamt;
      OP_SRA:   result = $unsigned($signed(b) >>> shamt);
      OP_LUI:   result = b << (WIDTH / 2);
      OP_MUL:   result = mul_res;
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
  end

  assign zero_d = wzero ? (result == '0) : zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu
// Build with or without ALU_MUL_EN; the MUL expectation follows the macro.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic        wzero;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .aluc   (aluc),
    .wzero  (wzero),
    .result (result),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, then let combinational logic settle.
  task automatic drive(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb, input logic wz);
    @(negedge clk);
    aluc  = op;
    a     = va;
    b     = vb;
    wzero = wz;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; a = '0; b = '0; aluc = 4'b0000; wzero = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_zero", {31'b0, zero}, 32'h0);

    drive(4'b0000, 32'd2, 32'd3, 1'b0);
    chk("add_during_reset", result, 32'd5);

    drive(4'b0000, 32'd0, 32'd0, 1'b1);
    edge_settle();
    chk("edge_in_reset_zero", {31'b0, zero}, 32'h0);

    @(negedge clk);
    rst = 1'b0;

    drive(4'b0000, 32'hFFFFFFFF, 32'd1, 1'b1);
    chk("add_wrap", result, 32'h0);
    edge_settle();
    chk("add_wrap_zero", {31'b0, zero}, 32'h1);

    drive(4'b0001, 32'd5, 32'd3, 1'b1);
    chk("sub", result, 32'd2);
    edge_settle();
    chk("sub_zero", {31'b0, zero}, 32'h0);

    drive(4'b0001, 32'd7, 32'd7, 1'b0);
    chk("sub_eq", result, 32'h0);
    edge_settle();
    chk("hold_zero", {31'b0, zero}, 32'h0);

    drive(4'b0000, 32'h7FFFFFFF, 32'd1, 1'b0);
    chk("add_ovf", result, 32'h80000000);
    drive(4'b0001, 32'd0, 32'd1, 1'b0);
    chk("sub_wrap", result, 32'hFFFFFFFF);

    drive(4'b0010, 32'hF0F000FF, 32'h0FF00F0F, 1'b0);
    chk("and", result, 32'h00F0000F);
    drive(4'b0011, 32'hF0F000FF, 32'h0FF00F0F, 1'b0);
    chk("or", result, 32'hFFF00FFF);
    drive(4'b0100, 32'hF0F000FF, 32'h0FF00F0F, 1'b0);
    chk("xor", result, 32'hFF000FF0);
    drive(4'b0101, 32'hF0F000FF, 32'h0FF00F0F, 1'b0);
    chk("nor", result, 32'h000FF000);

    drive(4'b0110, 32'hFFFFFFFF, 32'd1, 1'b0);
    chk("slt_neg", result, 32'd1);
    drive(4'b0111, 32'hFFFFFFFF, 32'd1, 1'b0);
    chk("sltu_big", result, 32'd0);
    drive(4'b0110, 32'd1, 32'hFFFFFFFF, 1'b0);
    chk("slt_pos", result, 32'd0);
    drive(4'b0111, 32'd1, 32'hFFFFFFFF, 1'b0);
    chk("sltu_small", result, 32'd1);

    drive(4'b1001, 32'd4, 32'h80000000, 1'b0);
    chk("srl", result, 32'h08000000);
    drive(4'b1010, 32'd4, 32'h80000000, 1'b0);
    chk("sra", result, 32'hF8000000);
    drive(4'b1010, 32'd4, 32'h40000000, 1'b0);
    chk("sra_pos", result, 32'h04000000);
    drive(4'b1000, 32'h00000025, 32'd1, 1'b0);
    chk("sll_masked", result, 32'h00000020);
    drive(4'b1000, 32'hFFFFFFE0, 32'h12345678, 1'b0);
    chk("sll_zero_amt", result, 32'h12345678);
    drive(4'b1010, 32'h00000020, 32'h87654321, 1'b0);
    chk("sra_zero_amt", result, 32'h87654321);
    drive(4'b1001, 32'd31, 32'hFFFFFFFF, 1'b0);
    chk("srl_31", result, 32'h00000001);

    drive(4'b1011, 32'hDEAD0000, 32'h00001234, 1'b0);
    chk("lui", result, 32'h12340000);

    drive(4'b1100, 32'd3, 32'h40000001, 1'b0);
`ifdef ALU_MUL_EN
    chk("mul", result, 32'hC0000003);
`else
    chk("mul_off", result, 32'h0);
`endif

    drive(4'b1101, 32'h11111111, 32'hDEADBEEF, 1'b0);
    chk("passb", result, 32'hDEADBEEF);
    drive(4'b1110, 32'h11111111, 32'hDEADBEEF, 1'b0);
    chk("op_1110", result, 32'h0);
    drive(4'b1111, 32'h11111111, 32'hDEADBEEF, 1'b0);
    chk("op_1111", result, 32'h0);

    // Set the flag, confirm wzero=0 holds a 1, then clear it asynchronously.
    drive(4'b0000, 32'd0, 32'd0, 1'b1);
    edge_settle();
    chk("set_zero", {31'b0, zero}, 32'h1);
    drive(4'b1101, 32'd0, 32'd9, 1'b0);
    edge_settle();
    chk("hold_one", {31'b0, zero}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_zero", {31'b0, zero}, 32'h0);
    chk("result_in_rst", result, 32'd9);
    #1 rst = 1'b0;

    drive(4'b0001, 32'd4, 32'd4, 1'b1);
    edge_settle();
    chk("post_rst_update", {31'b0, zero}, 32'h1);
    drive(4'b0000, 32'd1, 32'd0, 1'b1);
    edge_settle();
    chk("nonzero_clears", {31'b0, zero}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the datapath width; the shift-amount field is the low log2(WIDTH) bits of a (5 bits at WIDTH=32).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; the zero flag updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port a, input, WIDTH bits: operand A; it carries the shift amount for shift operations.
REQ-005 The module SHALL have port b, input, WIDTH bits: operand B; it is the value shifted for shift operations.
REQ-006 The module SHALL have port aluc, input, 4 bits: operation select.
REQ-007 The module SHALL have port wzero, input, 1 bit: zero-flag write enable.
REQ-008 The module SHALL have port result, output, WIDTH bits: combinational operation result.
REQ-009 The module SHALL have port zero, output, 1 bit: registered zero flag.

Function
REQ-010 result SHALL be purely combinational from a, b and aluc, with zero cycles of latency and no dependence on clk or rst.
REQ-011 aluc SHALL decode as follows:
- 0000 ADD: a+b, wrap modulo 2^WIDTH, carry discarded.
- 0001 SUB: a-b, wrap modulo 2^WIDTH.
- 0010 AND; 0011 OR; 0100 XOR; 0101 NOR.
- 0110 SLT: 1 if a<b signed, else 0, zero-extended.
- 0111 SLTU: 1 if a<b unsigned, else 0, zero-extended.
- 1000 SLL: b << a[4:0].
- 1001 SRL: b >> a[4:0], zero fill.
- 1010 SRA: b >> a[4:0], sign fill from b[WIDTH-1].
- 1011 LUI: b << (WIDTH/2).
- 1100 MUL: see REQ-019.
- 1101 PASSB: b.
- 1110 and 1111: result 0.
REQ-012 Shift operations SHALL ignore a[WIDTH-1:5]; a shift amount of 0 SHALL return b unchanged.
REQ-013 Overflow SHALL produce no flag and no exception; the result is the wrapped value.
REQ-014 On each rising clk edge with wzero=1 and rst=0, zero SHALL load (result == 0) as evaluated from that cycle's inputs.
REQ-015 On a rising clk edge with wzero=0, zero SHALL hold its value.
REQ-016 zero SHALL reflect only the result of the most recent enabled cycle, so a branch in the following cycle sees the flag.

Reset
REQ-017 While rst=1, zero SHALL be 0 immediately, regardless of clk; result is unaffected by rst.
REQ-018 When rst deasserts, the first rising edge with wzero=1 SHALL update zero normally; an edge coinciding with rst=1 SHALL leave zero at 0.

Configuration
REQ-019 Macro ALU_MUL_EN SHALL control the MUL operation:
- Defined: aluc=1100 returns the low WIDTH bits of the unsigned product a*b.
- Undefined: aluc=1100 returns 0, and no multiplier logic is synthesized.

Verification
REQ-020 ADD wrap: a=32'hFFFFFFFF, b=1, aluc=0000 -> result=0; with wzero=1 for one clock edge -> zero=1.
REQ-021 SUB then hold: a=5, b=3, aluc=0001, wzero=1 -> result=2 and zero=0 after the edge; then wzero=0 with a=b=7 -> zero stays 0.
REQ-022 Signed versus unsigned compare: a=32'hFFFFFFFF, b=1 -> SLT result=1; SLTU result=0.
REQ-023 Shifts: b=32'h80000000, a=4 -> SRL=32'h08000000, SRA=32'hF8000000; SLL with b=1, a=32'h00000025 -> 32'h00000020.
REQ-024 Async reset: set zero=1, then pulse rst=1 between clock edges -> zero=0 immediately; LUI with b=32'h00001234 -> 32'h12340000.
REQ-025 MUL with a=3, b=32'h40000001 -> result=32'h C0000003 when ALU_MUL_EN is defined, and 0 when it is undefined.
